// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp plus msip on a 32-bit request/ready bus.
// Optional build macro CLINT_MTIME_SNAPSHOT_EN makes a read of mtime[31:0] latch mtime[63:32] for a torn-free read of 0xBFFC.
module clint_timer #(
    parameter int unsigned PRESCALE     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [15:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        msip,
    output logic        mtip
);

    localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

    localparam logic [13:0] W_MSIP    = 14'h0000;
    localparam logic [13:0] W_CMP_LO  = 14'h1000;
    localparam logic [13:0] W_CMP_HI  = 14'h1001;
    localparam logic [13:0] W_TIME_LO = 14'h2FFE;
    localparam logic [13:0] W_TIME_HI = 14'h2FFF;

    logic [15:0] cnt_q, cnt_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        mtip_q, mtip_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic [31:0] shadow_q, shadow_d;

    logic [13:0] word_s;
    logic        wr_s;
    logic        rd_s;
    logic        tick_s;
    logic [31:0] rd_val_s;
    logic        unused_addr_s;

    assign word_s        = bus_addr[15:2];
    assign unused_addr_s = ^bus_addr[1:0];
    assign wr_s          = bus_req & bus_we;
    assign rd_s          = bus_req & ~bus_we;
    assign tick_s        = (cnt_q == PRESCALE_MAX);

    // Prescaler wraps after PRESCALE cycles and issues one tick.
    always_comb begin
        if (tick_s) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // mtime: a write to either half wins over the tick, leaving the other half untouched.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_s && (word_s == W_TIME_LO)) begin
            mtime_d = {mtime_q[63:32], bus_wdata};
        end else if (wr_s && (word_s == W_TIME_HI)) begin
            mtime_d = {bus_wdata, mtime_q[31:0]};
        end else if (tick_s) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
    end

    // Software-writable mtimecmp halves and msip bit.
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr_s) begin
            case (word_s)
                W_MSIP:   msip_d = bus_wdata[0];
                W_CMP_LO: mtimecmp_d = {mtimecmp_q[63:32], bus_wdata};
                W_CMP_HI: mtimecmp_d = {bus_wdata, mtimecmp_q[31:0]};
                default:  mtimecmp_d = mtimecmp_q;
            endcase
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
    end

    // Read mux samples register values before this cycle's updates.
    always_comb begin
        case (word_s)
            W_MSIP:    rd_val_s = {31'd0, msip_q};
            W_CMP_LO:  rd_val_s = mtimecmp_q[31:0];
            W_CMP_HI:  rd_val_s = mtimecmp_q[63:32];
            W_TIME_LO: rd_val_s = mtime_q[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
            W_TIME_HI: rd_val_s = shadow_q;
`else
            W_TIME_HI: rd_val_s = mtime_q[63:32];
`endif
            default:   rd_val_s = 32'd0;
        endcase
    end

    // Bus response, snapshot shadow and timer compare next-state.
    always_comb begin
        ready_d = bus_req;
        if (rd_s) begin
            rdata_d = rd_val_s;
        end else begin
            rdata_d = 32'd0;
        end
`ifdef CLINT_MTIME_SNAPSHOT_EN
        if (rd_s && (word_s == W_TIME_LO)) begin
            shadow_d = mtime_q[63:32];
        end else begin
            shadow_d = shadow_q;
        end
`else
        shadow_d = 32'd0;
`endif
        mtip_d = (mtime_q >= mtimecmp_q);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 16'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            rdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            shadow_q   <= 32'd0;
        end else begin
            cnt_q      <= cnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            shadow_q   <= shadow_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign bus_ready = ready_q;
    assign msip      = msip_q;
    assign mtip      = mtip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (PRESCALE 1 and 4) checked every cycle against a spec-level model, plus directed scenarios.
module tb_clint_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [15:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        msip_w[2];
    logic        mtip_w[2];

    always #5 clk = ~clk;

    clint_timer #(.PRESCALE(1)) u_p1 (
        .clk(clk), .rst(rst), .bus_req(req[0]), .bus_we(we[0]), .bus_addr(addr[0]),
        .bus_wdata(wdata[0]), .bus_rdata(rdata[0]), .bus_ready(ready[0]),
        .msip(msip_w[0]), .mtip(mtip_w[0])
    );

    clint_timer #(.PRESCALE(4)) u_p4 (
        .clk(clk), .rst(rst), .bus_req(req[1]), .bus_we(we[1]), .bus_addr(addr[1]),
        .bus_wdata(wdata[1]), .bus_rdata(rdata[1]), .bus_ready(ready[1]),
        .msip(msip_w[1]), .mtip(mtip_w[1])
    );

    // Reference state: what software would see in each CLINT
    logic [63:0] m_time  [2];
    logic [63:0] m_cmp   [2];
    logic        m_msip  [2];
    logic        m_mtip  [2];
    logic [31:0] m_shadow[2];
    int unsigned m_phase [2];
    int unsigned m_pre   [2];
    logic        e_ready [2];
    logic [31:0] e_rdata [2];

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int i, input logic [15:0] a);
        logic [15:0] wa;
        wa = {a[15:2], 2'b00};
        case (wa)
            16'h0000: return {31'd0, m_msip[i]};
            16'h4000: return m_cmp[i][31:0];
            16'h4004: return m_cmp[i][63:32];
            16'hBFF8: return m_time[i][31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
            16'hBFFC: return m_shadow[i];
`else
            16'hBFFC: return m_time[i][63:32];
`endif
            default:  return 32'd0;
        endcase
    endfunction

    // One clock: advance the model by the rules for this edge and compare all outputs.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            logic        tick;
            logic [15:0] wa;
            if (rst) begin
                m_time[i]   = 64'd0;
                m_cmp[i]    = 64'hFFFF_FFFF_FFFF_FFFF;
                m_msip[i]   = 1'b0;
                m_mtip[i]   = 1'b0;
                m_shadow[i] = 32'd0;
                m_phase[i]  = 0;
                e_ready[i]  = 1'b0;
                e_rdata[i]  = 32'd0;
            end else begin
                wa = {addr[i][15:2], 2'b00};
                e_ready[i] = req[i];
                e_rdata[i] = (req[i] && !we[i]) ? model_read(i, addr[i]) : 32'd0;
                if (req[i] && !we[i] && wa == 16'hBFF8) m_shadow[i] = m_time[i][63:32];
                m_mtip[i]  = (m_time[i] >= m_cmp[i]);
                m_phase[i] = (m_phase[i] + 1) % m_pre[i];
                tick = (m_phase[i] == 0);
                if (req[i] && we[i]) begin
                    case (wa)
                        16'h0000: m_msip[i] = wdata[i][0];
                        16'h4000: m_cmp[i][31:0] = wdata[i];
                        16'h4004: m_cmp[i][63:32] = wdata[i];
                        16'hBFF8: begin m_time[i][31:0] = wdata[i]; tick = 1'b0; end
                        16'hBFFC: begin m_time[i][63:32] = wdata[i]; tick = 1'b0; end
                        default: ;
                    endcase
                end
                if (tick) m_time[i] = m_time[i] + 64'd1;
            end
            check($sformatf("u%0d.bus_ready", i), 64'(ready[i]),  64'(e_ready[i]));
            check($sformatf("u%0d.bus_rdata", i), 64'(rdata[i]),  64'(e_rdata[i]));
            check($sformatf("u%0d.msip", i),      64'(msip_w[i]), 64'(m_msip[i]));
            check($sformatf("u%0d.mtip", i),      64'(mtip_w[i]), 64'(m_mtip[i]));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic access(input int i, input logic w, input logic [15:0] a,
                          input logic [31:0] wd, output logic [31:0] rd);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = wd;
        step();
        rd = rdata[i];
        req[i] = 1'b0; we[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bit seen;
        m_pre[0] = 1;
        m_pre[1] = 4;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 16'd0; wdata[i] = 32'd0;
        end
        do_reset();
        check("reset.mtip", 64'(mtip_w[0]), 64'd0);
        check("reset.msip", 64'(msip_w[0]), 64'd0);
        check("reset.ready", 64'(ready[0]), 64'd0);

        // Idle after reset, then read mtime and mtimecmp
        idle(10);
        access(0, 1'b0, 16'hBFF8, 32'd0, d);
        check("idle10.mtime_in_9_11", 64'((d >= 32'd9) && (d <= 32'd11)), 64'd1);
        access(0, 1'b0, 16'h4000, 32'd0, d);
        check("reset.mtimecmp_lo", 64'(d), 64'hFFFF_FFFF);

        // msip set/read/clear
        access(0, 1'b1, 16'h0000, 32'h3, d);
        check("msip.set", 64'(msip_w[0]), 64'd1);
        access(0, 1'b0, 16'h0000, 32'd0, d);
        check("msip.read", 64'(d), 64'd1);
        access(0, 1'b1, 16'h0000, 32'h0, d);
        check("msip.clear", 64'(msip_w[0]), 64'd0);

        // mtip rises one cycle after mtime reaches 20, so mtime reads 21 then
        do_reset();
        access(0, 1'b1, 16'h4004, 32'd0, d);
        access(0, 1'b1, 16'h4000, 32'd20, d);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (mtip_w[0]) seen = 1'b1;
            else step();
        end
        check("mtip.rise_within_budget", 64'(seen), 64'd1);
        access(0, 1'b0, 16'hBFF8, 32'd0, d);
        check("mtip.rise_mtime", 64'(d), 64'd21);
        access(0, 1'b1, 16'h4000, 32'hFFFF_FFFF, d);
        access(0, 1'b1, 16'h4004, 32'hFFFF_FFFF, d);
        step();
        check("mtip.drop", 64'(mtip_w[0]), 64'd0);

        // Carry from lo into hi, and write beating a coincident tick
        access(0, 1'b1, 16'hBFF8, 32'hFFFF_FFFF, d);
        access(0, 1'b1, 16'hBFFC, 32'd0, d);
        step();
        access(0, 1'b0, 16'hBFF8, 32'd0, d);
        check("carry.lo", 64'(d), 64'd0);
        access(0, 1'b0, 16'hBFFC, 32'd0, d);
        check("carry.hi", 64'(d), 64'd1);
        access(0, 1'b1, 16'hBFF8, 32'h1234_5678, d);
        access(0, 1'b0, 16'hBFF8, 32'd0, d);
        check("write_vs_tick", 64'(d), 64'h1234_5678);

        // PRESCALE = 4 instance
        do_reset();
        idle(12);
        access(1, 1'b0, 16'hBFF8, 32'd0, d);
        check("p4.mtime_12", 64'(d), 64'd3);
        idle(3);
        access(1, 1'b0, 16'hBFF8, 32'd0, d);
        check("p4.mtime_16", 64'(d), 64'd4);

        // Unmapped read
        access(0, 1'b0, 16'h1234, 32'd0, d);
        check("unmapped.rdata", 64'(d), 64'd0);
        check("unmapped.ready", 64'(ready[0]), 64'd1);

        // Reset on the edge that would complete a request
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'hBFF8; rst = 1'b1;
        step();
        req[0] = 1'b0; rst = 1'b0;
        check("reset_mid_access.ready", 64'(ready[0]), 64'd0);

        // Randomized traffic on both instances
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                req[i] = ($urandom_range(0, 3) != 0);
                we[i]  = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 5))
                    0: addr[i] = 16'h0000;
                    1: addr[i] = 16'h4000;
                    2: addr[i] = 16'h4004;
                    3: addr[i] = 16'hBFF8;
                    4: addr[i] = 16'hBFFC;
                    default: addr[i] = 16'($urandom);
                endcase
                wdata[i] = (addr[i] == 16'h4000) ? 32'($urandom_range(0, 600)) :
                           (addr[i] == 16'h4004 || addr[i] == 16'hBFFC) ? 32'($urandom_range(0, 1)) :
                           32'($urandom);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0;
        end

        // Torn-read scenario straddling the lo->hi carry
        access(0, 1'b1, 16'hBFFC, 32'd0, d);
        access(0, 1'b1, 16'hBFF8, 32'hFFFF_FFFE, d);
        access(0, 1'b0, 16'hBFF8, 32'd0, d);
        check("snap.lo", 64'(d), 64'hFFFF_FFFE);
        step();
        access(0, 1'b0, 16'hBFFC, 32'd0, d);
`ifdef CLINT_MTIME_SNAPSHOT_EN
        check("snap.hi", 64'(d), 64'd0);
`else
        check("snap.hi", 64'(d), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
